// File: rtl/uart_rx_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : 16x-oversampling 8N1 UART receiver with 2-flop synchroniser,
//            3-sample majority vote, false-start rejection and framing-error
//            strobe. Held-low (break) lines yield a single frame_err.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dat,
  output logic       dat_en,
  output logic       frame_err,
  output logic       busy
);

  // Clocks per oversampling tick, rounded to nearest.
  localparam int DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx_sampler: CLK_FREQ too low for BAUD (DIV < 1)");
    end
  endgenerate

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          sync1;
  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    sub_cnt;
  logic [2:0]    samples;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          counting;
  logic          tick;
  logic          maj_bit;
  logic          maj_stop;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Counters only run inside a frame; IDLE and BREAK hold them at zero so a
  // new frame always starts its bit period from a clean phase.
  assign counting = (state == START) || (state == DATA) || (state == STOP);
  assign tick     = counting && (tick_cnt == TICK_LAST);
  assign maj_bit  = maj3(samples);
  // Stop bit is decided on the tick that captures its third sample, so the
  // live rx_s stands in for the sample not yet registered.
  assign maj_stop = maj3({samples[1:0], rx_s});
  assign busy     = (state != IDLE);

  // Two-flop synchroniser; reset to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Oversampling tick divider and 16-phase sub-bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      sub_cnt  <= 4'd0;
    end else if (!counting) begin
      tick_cnt <= '0;
      sub_cnt  <= 4'd0;
    end else if (tick) begin
      tick_cnt <= '0;
      sub_cnt  <= sub_cnt + 4'd1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Mid-bit sample capture at sub-phases 7, 8 and 9.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples <= 3'b000;
    end else if (tick && (sub_cnt >= 4'd7) && (sub_cnt <= 4'd9)) begin
      samples <= {samples[1:0], rx_s};
    end
  end

  // Frame state machine, shift register and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      dat       <= 8'h00;
      dat_en    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dat_en    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick && (sub_cnt == 4'd15)) begin
            // A start bit that does not vote low was a glitch.
            state <= maj_bit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick && (sub_cnt == 4'd15)) begin
            shreg   <= {maj_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          // Deciding at mid-bit leaves margin to catch a back-to-back start.
          if (tick && (sub_cnt == 4'd9)) begin
            if (maj_stop) begin
              dat    <= shreg;
              dat_en <= 1'b1;
              state  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

16x-oversampling UART receiver sitting directly upstream of the boot loader's byte-to-word converter. It turns the asynchronous `rx` line into validated 8-bit bytes, each accompanied by a one-cycle `dat_en` strobe. It adds input synchronisation, 3-sample majority voting, false-start rejection and framing-error reporting, so that corrupted frames never reach the boot RAM image.

## Interface
- `CLK_FREQ`, default 100_000_000: clk frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `DIV`, derived, not overridable: `(CLK_FREQ + BAUD*8) / (BAUD*16)`, rounded to nearest.
  - Elaboration error if `DIV < 1`.
  - Default value is 54.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `rx`, input, 1: asynchronous serial line. Idle high; 8N1, LSB first.
- `dat`, output, 8: last good byte. Held until the next good frame.
- `dat_en`, output, 1: one-clk strobe. `dat` is valid in the same cycle.
- `frame_err`, output, 1: one-clk strobe. Stop bit was sampled low.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- **Synchroniser:** two flops on `rx`, both reset to 1; the output is `rx_s`. All logic uses `rx_s` only.
- **Tick generator:**
  - `tick_cnt` counts 0..DIV-1. `tick` is asserted on the cycle where `tick_cnt == DIV-1`, and `tick_cnt` wraps to 0.
  - `sub_cnt` (4 bits) increments on each `tick` and wraps 15→0. Each wrap ends one bit period.
  - Leaving IDLE clears both `tick_cnt` and `sub_cnt`.
- **Sampling:**
  - On a `tick` where `sub_cnt` ∈ {7, 8, 9}, capture `rx_s` into a 3-bit sample register.
  - The bit value is the majority of the 3 samples (≥2 ones → 1).
- **States:**
  - IDLE: if `rx_s == 0` → START.
  - START: on the tick with `sub_cnt == 15`, go to DATA if the majority is 0. Otherwise (false start/glitch) go to IDLE, with no output.
  - DATA:
    - On each tick with `sub_cnt == 15`, shift the majority bit into `shreg` from the MSB side (LSB-first line order).
    - `bit_cnt` counts 0..7. After bit 7 → STOP.
  - STOP: on the tick with `sub_cnt == 9`, after the third sample is captured, take the majority.
    - Majority 1: `dat <= shreg`, pulse `dat_en`, → IDLE.
    - Majority 0: pulse `frame_err`, `dat` unchanged, → BREAK.
  - BREAK: wait for `rx_s == 1`, then → IDLE. A held-low line (break) therefore produces exactly one `frame_err` and no repeated frames.
- **Mid-stop return:** leaving STOP at mid-bit gives ≥6 ticks of margin, so a following start edge is still detected when frames are back-to-back.
- **Strobes:** `dat_en` and `frame_err` are registered and never both high. Each is high for exactly one clk per frame.
- **No flow control:** the consumer must accept `dat_en` on the cycle it occurs.

## Timing
- **Reset values:**
  - State = IDLE; `dat` = 0x00; `dat_en` = `frame_err` = `busy` = 0.
  - Synchroniser flops = 1.
  - All counters and `shreg` = 0.
- **Entering START:** the state leaves IDLE 3 clks after `rx` falls (2 synchroniser clks + 1 state-register clk). `busy` rises in that same cycle.
- **Result latency:** with T0 = the first cycle in START, `dat_en` or `frame_err` is high in cycle T0 + DIV·154. That is 9 bit periods plus 10 ticks.
- **Stop-decision cycle:** `busy` stays high through the cycle in which the stop bit is decided. In the strobe cycle it is 0, except on a framing error, where it stays high in BREAK.
- **Reset mid-frame:** all state is cleared immediately. A partial byte is discarded, with no strobe. The next full frame received after reset release decodes normally.

## Test plan
- **Reset:** assert `rst` mid-operation → all outputs at their reset values within the same cycle; `busy` = 0.
- **Single byte:** `CLK_FREQ` = 1_600_000, `BAUD` = 100_000 (DIV = 1, 16 clk/bit). Send 0xA5 → `dat` = 0xA5 with `dat_en` high for exactly 1 clk, at T0 + 154; `frame_err` stays 0.
- **Glitch:** drive `rx` low for 5 clks, then high → state returns to IDLE after START; no `dat_en`; `dat` keeps its previous value.
- **Noise rejection:** send 0x3C with one sample-point clk (`sub_cnt` = 8) inverted in bit 2 → `dat` = 0x3C (majority vote).
- **Framing error:** send 0x55 with stop bit 0, then hold `rx` low for 100 clks → exactly one `frame_err` pulse; `dat` unchanged; `busy` high until `rx` returns high. A following 0x81 frame is received correctly.
- **Back-to-back:** send 0x00, 0xFF, 0x7E with zero idle gap → three `dat_en` pulses 160 clks apart, with `dat` = 0x00, 0xFF, 0x7E in order.
